prbs_sym_gen: RTL

//  Parametrised maximal-length Fibonacci LFSR that generates PRBS symbols for data payload simulation.

---
 rtl/prbs_sym_gen.sv | 73 +++++++
 1 files changed

// File: rtl/prbs_sym_gen.sv
// Parametrised Fibonacci LFSR producing SYM_BITS-wide PRBS symbols, with
// runtime seed load and a period counter that flags each return to the seed.
module prbs_sym_gen #(
  parameter int             N        = 22,
  parameter logic [N-1:0]   TAPS     = 22'h300000,
  parameter int             SYM_BITS = 2,
  parameter logic [N-1:0]   SEED_DEF = 22'h000001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                load,
  input  logic [N-1:0]        seed_in,
  output logic [N-1:0]        state_out,
  output logic [SYM_BITS-1:0] sym_out,
  output logic [N-1:0]        sym_count,
  output logic                last_sym,
  output logic                wrap,
  output logic                wrap_seen
);

  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] SEED_RST = (SEED_DEF == '0) ? ONE : SEED_DEF;

  logic [N-1:0] state;
  logic [N-1:0] seed_reg;
  logic [N-1:0] nxt;
  logic [N-1:0] seed_safe;

  // SYM_BITS chained single shifts, all within one clock
  always_comb begin
    nxt = state;
    for (int i = 0; i < SYM_BITS; i++) begin
      nxt = {nxt[N-2:0], ^(nxt & TAPS)};
    end
  end

  // an all-zero seed would lock the LFSR, so it is replaced by 1
  assign seed_safe = (seed_in == '0) ? ONE : seed_in;
  assign last_sym  = (nxt == seed_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEED_RST;
      seed_reg  <= SEED_RST;
      sym_count <= '0;
      wrap      <= 1'b0;
      wrap_seen <= 1'b0;
    end else if (load) begin
      state     <= seed_safe;
      seed_reg  <= seed_safe;
      sym_count <= '0;
      wrap      <= 1'b0;
      wrap_seen <= 1'b0;
    end else if (clk_en) begin
      state <= nxt;
      if (last_sym) begin
        sym_count <= '0;
        wrap      <= 1'b1;
        wrap_seen <= 1'b1;
      end else begin
        sym_count <= sym_count + ONE;
        wrap      <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign state_out = state;
  assign sym_out   = state[N-1 -: SYM_BITS];

endmodule
